// File: rtl/store_buffer_pkg.sv
// Store buffer package: geometry constants, entry record and the address
// overlap helpers shared by the CAM and the bench.
//   SB_DEPTH  : number of buffered stores (power of two, >= 2)
//   SB_ADDR_W : byte address width
//   SB_DATA_W : halfword data width (little-endian, byte addressed memory)
package store_buffer_pkg;
  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 16;
  localparam int SB_DATA_W = 16;
  localparam int SB_PTR_W  = $clog2(SB_DEPTH);
  localparam int SB_CNT_W  = $clog2(SB_DEPTH) + 1;

  typedef logic [SB_ADDR_W-1:0] sb_addr_t;
  typedef logic [SB_DATA_W-1:0] sb_data_t;
  typedef logic [SB_PTR_W-1:0]  sb_ptr_t;
  typedef logic [SB_CNT_W-1:0]  sb_cnt_t;

  typedef struct packed {
    logic     valid;
    sb_addr_t addr;
    sb_data_t data;
  } sb_entry_t;

  function automatic logic addr_exact(input sb_addr_t entry, input sb_addr_t ld);
    return entry == ld;
  endfunction

  // A halfword at ld+/-1 shares one byte with the load; addresses wrap.
  function automatic logic addr_partial(input sb_addr_t entry, input sb_addr_t ld);
    return (entry == ld + sb_addr_t'(1)) || (entry == ld - sb_addr_t'(1));
  endfunction
endpackage

// File: rtl/store_buffer_if.sv
// Store buffer bus: MEM-stage store/load requests plus the data memory port.
//   master : pipeline / memory side (drives requests and mem_read_data)
//   slave  : the store buffer
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic     st_valid;
  sb_addr_t st_addr;
  sb_data_t st_data;
  logic     ld_valid;
  sb_addr_t ld_addr;
  sb_data_t ld_data;
  logic     stall;
  logic     sb_empty;
  sb_addr_t mem_address;
  sb_data_t mem_write_data;
  logic     mem_write;
  logic     mem_read;
  sb_data_t mem_read_data;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
    input  ld_data, stall, sb_empty, mem_address, mem_write_data, mem_write, mem_read
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
    output ld_data, stall, sb_empty, mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/store_buffer_match.sv
// Combinational CAM over all store buffer entries.
//   entries : entry array (valid/addr/data)
//   tail    : next allocation slot, used to rank entry age
//   ld_addr : load byte address
//   exact   : per-entry exact address match
//   partial : per-entry one-byte overlap
//   hit_idx : youngest exactly matching entry (meaningful when |exact)
module store_buffer_match
  import store_buffer_pkg::*;
(
  input  sb_entry_t             entries [SB_DEPTH],
  input  sb_ptr_t               tail,
  input  sb_addr_t              ld_addr,
  output logic [SB_DEPTH-1:0]   exact,
  output logic [SB_DEPTH-1:0]   partial,
  output sb_ptr_t               hit_idx
);
  sb_ptr_t idx;

  always_comb begin
    exact   = '0;
    partial = '0;
    hit_idx = '0;
    idx     = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      exact[i]   = entries[i].valid && addr_exact(entries[i].addr, ld_addr);
      partial[i] = entries[i].valid && addr_partial(entries[i].addr, ld_addr);
    end
    // Walk from tail (oldest slot) forward; the last match seen is the youngest.
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = tail + sb_ptr_t'(k);
      if (exact[idx]) hit_idx = idx;
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between EX/MEM and the data memory.
// Accepts one store per cycle, drains the oldest entry to memory whenever a
// load does not need the port, forwards loads from the youngest exact match
// and stalls on full or on a partially overlapping load.
//   clk, rst : clock, synchronous active-high reset
//   sb       : request / memory port bundle (slave side)
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  store_buffer_if.slave     sb
);
  sb_entry_t             entries [SB_DEPTH];
  sb_ptr_t               head, tail;
  sb_cnt_t               count;
  logic [SB_DEPTH-1:0]   exact, partial;
  sb_ptr_t               hit_idx;

  logic ld_hit_raw, ld_conflict_raw, ld_miss_raw, ld_live;
  logic ld_hit, ld_conflict, ld_miss;
  logic drain_en, full, enq;

  store_buffer_match u_match (
    .entries (entries),
    .tail    (tail),
    .ld_addr (sb.ld_addr),
    .exact   (exact),
    .partial (partial),
    .hit_idx (hit_idx)
  );

  always_comb begin
    ld_hit_raw      = sb.ld_valid && (|exact) && !(|partial);
    ld_conflict_raw = sb.ld_valid && (|partial);
    ld_miss_raw     = sb.ld_valid && !ld_hit_raw && !ld_conflict_raw;
    // A load issued alongside a store is ignored for its results, but a
    // would-be miss still reserves the memory port so draining pauses.
    ld_live     = !rst && !sb.st_valid;
    ld_hit      = ld_hit_raw && ld_live;
    ld_conflict = ld_conflict_raw && ld_live;
    ld_miss     = ld_miss_raw && ld_live;
    drain_en    = !rst && (count != '0) && !ld_miss_raw;
    full        = (count == sb_cnt_t'(SB_DEPTH));
    sb.stall    = (!rst && sb.st_valid && full && !drain_en) || ld_conflict;
    enq         = !rst && sb.st_valid && !sb.stall;

    sb.mem_read       = 1'b0;
    sb.mem_write      = 1'b0;
    sb.mem_address    = '0;
    sb.mem_write_data = '0;
    sb.ld_data        = '0;
    if (ld_miss) begin
      sb.mem_read    = 1'b1;
      sb.mem_address = sb.ld_addr;
      sb.ld_data     = sb.mem_read_data;
    end else if (drain_en) begin
      sb.mem_write      = 1'b1;
      sb.mem_address    = entries[head].addr;
      sb.mem_write_data = entries[head].data;
    end
    if (ld_hit) sb.ld_data = entries[hit_idx].data;
  end

  assign sb.sb_empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < SB_DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      // Drain first so a same-cycle enqueue into the freed slot (full case)
      // keeps its valid bit.
      if (drain_en) begin
        entries[head].valid <= 1'b0;
        head <= head + sb_ptr_t'(1);
      end
      if (enq) begin
        entries[tail] <= '{valid: 1'b1, addr: sb.st_addr, data: sb.st_data};
        tail <= tail + sb_ptr_t'(1);
      end
      case ({enq, drain_en})
        2'b10:   count <= count + sb_cnt_t'(1);
        2'b01:   count <= count - sb_cnt_t'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_buffer_if sbif ();

  store_buffer dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif.slave)
  );

  // Data memory seen by the DUT; unwritten locations read a fixed pattern.
  bit [15:0] mem_arr [256];
  bit        written [256];

  always @(posedge clk) begin
    if (sbif.mem_write) begin
      mem_arr[sbif.mem_address[7:0]] <= sbif.mem_write_data;
      written[sbif.mem_address[7:0]] <= 1'b1;
    end
  end

  always_comb
    sbif.mem_read_data = written[sbif.mem_address[7:0]] ? mem_arr[sbif.mem_address[7:0]]
                                                        : (sbif.mem_address ^ 16'hC3C3);

  // Reference model: pending stores in program order plus expected memory image.
  typedef struct { logic [15:0] addr; logic [15:0] data; } st_t;
  st_t       q [$];
  bit [15:0] exp_mem [256];
  bit        exp_wr  [256];

  logic        e_stall, e_empty, e_mw, e_mr, e_drain, e_enq;
  logic [15:0] e_addr, e_wdata, e_ldata;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [15:0] a);
    return exp_wr[a[7:0]] ? exp_mem[a[7:0]] : (a ^ 16'hC3C3);
  endfunction

  task automatic model_eval();
    bit ex, pa, hit, conf, miss, raw_miss, live;
    logic [15:0] yd, lp, lm;
    ex = 0; pa = 0; yd = '0;
    lp = sbif.ld_addr + 16'd1;
    lm = sbif.ld_addr - 16'd1;
    foreach (q[i]) begin
      if (q[i].addr == sbif.ld_addr) begin ex = 1; yd = q[i].data; end
      if (q[i].addr == lp || q[i].addr == lm) pa = 1;
    end
    e_empty = (q.size() == 0);
    e_stall = 0; e_mw = 0; e_mr = 0; e_addr = '0; e_wdata = '0; e_ldata = '0;
    e_drain = 0; e_enq = 0;
    if (!rst) begin
      raw_miss = sbif.ld_valid && !(ex && !pa) && !pa;
      live     = !sbif.st_valid;
      hit      = sbif.ld_valid && ex && !pa && live;
      conf     = sbif.ld_valid && pa && live;
      miss     = raw_miss && live;
      e_drain  = (q.size() != 0) && !raw_miss;
      e_stall  = (sbif.st_valid && q.size() == 4 && !e_drain) || conf;
      e_enq    = sbif.st_valid && !e_stall;
      if (miss) begin
        e_mr = 1; e_addr = sbif.ld_addr; e_ldata = exp_read(sbif.ld_addr);
      end else if (e_drain) begin
        e_mw = 1; e_addr = q[0].addr; e_wdata = q[0].data;
      end
      if (hit) e_ldata = yd;
    end
  endtask

  task automatic model_step();
    if (rst) q.delete();
    else begin
      if (e_drain) begin
        exp_mem[q[0].addr[7:0]] = q[0].data;
        exp_wr[q[0].addr[7:0]]  = 1'b1;
        void'(q.pop_front());
      end
      if (e_enq) q.push_back('{addr: sbif.st_addr, data: sbif.st_data});
    end
  endtask

  // Apply inputs, then at the falling edge compare every output against the model.
  task automatic drive(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                       input logic lv, input logic [15:0] la, input logic r);
    sbif.st_valid = sv; sbif.st_addr = sa; sbif.st_data = sd;
    sbif.ld_valid = lv; sbif.ld_addr = la; rst = r;
    @(negedge clk);
    model_eval();
    chk("stall",          {31'd0, sbif.stall},     {31'd0, e_stall});
    chk("sb_empty",       {31'd0, sbif.sb_empty},  {31'd0, e_empty});
    chk("mem_write",      {31'd0, sbif.mem_write}, {31'd0, e_mw});
    chk("mem_read",       {31'd0, sbif.mem_read},  {31'd0, e_mr});
    chk("mem_address",    {16'd0, sbif.mem_address},    {16'd0, e_addr});
    chk("mem_write_data", {16'd0, sbif.mem_write_data}, {16'd0, e_wdata});
    chk("ld_data",        {16'd0, sbif.ld_data},        {16'd0, e_ldata});
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                     input logic lv, input logic [15:0] la, input logic r);
    drive(sv, sa, sd, lv, la, r);
    advance();
  endtask

  initial begin
    // Reset
    drive(0, 0, 0, 0, 0, 1);
    chk("rst_mem_write", {31'd0, sbif.mem_write}, 32'd0);
    advance();
    cyc(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_empty", {31'd0, sbif.sb_empty}, 32'd1);
    chk("rst_stall", {31'd0, sbif.stall}, 32'd0);
    advance();

    // 1: single store drains the next cycle
    drive(1, 16'h0010, 16'h1234, 0, 0, 0);
    chk("t1_no_write_yet", {31'd0, sbif.mem_write}, 32'd0);
    advance();
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_write", {31'd0, sbif.mem_write}, 32'd1);
    chk("t1_addr", {16'd0, sbif.mem_address}, 32'h0010);
    chk("t1_data", {16'd0, sbif.mem_write_data}, 32'h1234);
    advance();
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_empty", {31'd0, sbif.sb_empty}, 32'd1);
    advance();

    // 2: youngest of two same-address stores is forwarded
    cyc(1, 16'h0020, 16'hAAAA, 1, 16'h0080, 0);
    cyc(1, 16'h0020, 16'hBBBB, 1, 16'h0080, 0);
    drive(0, 0, 0, 1, 16'h0020, 0);
    chk("t2_ld_data", {16'd0, sbif.ld_data}, 32'hBBBB);
    chk("t2_mem_read", {31'd0, sbif.mem_read}, 32'd0);
    chk("t2_stall", {31'd0, sbif.stall}, 32'd0);
    advance();
    cyc(0, 0, 0, 0, 0, 0);
    chk("t2_mem20", {16'd0, 16'(mem_arr[8'h20])}, 32'hBBBB);

    // 3: fill while missing loads hold the port; 5th store waits for a drain
    for (int i = 0; i < 4; i++)
      cyc(1, 16'h0040 + 16'(2 * i), 16'h3000 + 16'(i), 1, 16'h0090, 0);
    drive(1, 16'h0048, 16'h3004, 1, 16'h0090, 0);
    chk("t3_full_stall", {31'd0, sbif.stall}, 32'd1);
    chk("t3_no_write", {31'd0, sbif.mem_write}, 32'd0);
    advance();
    drive(1, 16'h0048, 16'h3004, 0, 0, 0);
    chk("t3_accept", {31'd0, sbif.stall}, 32'd0);
    chk("t3_drain_addr", {16'd0, sbif.mem_address}, 32'h0040);
    advance();

    // 5: reset mid-drain discards the rest
    drive(0, 0, 0, 0, 0, 0);
    chk("t5_drain", {16'd0, sbif.mem_write_data}, 32'h3001);
    advance();
    drive(0, 0, 0, 0, 0, 1);
    chk("t5_rst_no_write", {31'd0, sbif.mem_write}, 32'd0);
    advance();
    drive(0, 0, 0, 0, 0, 0);
    chk("t5_empty", {31'd0, sbif.sb_empty}, 32'd1);
    chk("t5_write", {31'd0, sbif.mem_write}, 32'd0);
    advance();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("t5_not_written", {31'd0, written[8'h44]}, 32'd0);

    // 4: partial overlap stalls until the store drains, then the load misses
    cyc(1, 16'h0030, 16'h5555, 0, 0, 0);
    drive(0, 0, 0, 1, 16'h0031, 0);
    chk("t4_stall", {31'd0, sbif.stall}, 32'd1);
    chk("t4_drain", {31'd0, sbif.mem_write}, 32'd1);
    advance();
    drive(0, 0, 0, 1, 16'h0031, 0);
    chk("t4_released", {31'd0, sbif.stall}, 32'd0);
    chk("t4_read", {31'd0, sbif.mem_read}, 32'd1);
    chk("t4_addr", {16'd0, sbif.mem_address}, 32'h0031);
    chk("t4_ld_data", {16'd0, sbif.ld_data}, 32'hC3F2);
    advance();

    // 6: store/drain pairs wrap the pointers; memory holds the last writes
    for (int i = 0; i < 10; i++) begin
      cyc(1, 16'h00A0 + 16'(2 * (i % 4)), 16'h6000 + 16'(i), 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
    end
    chk("t6_a0", {16'd0, 16'(mem_arr[8'hA0])}, 32'h6008);
    chk("t6_a2", {16'd0, 16'(mem_arr[8'hA2])}, 32'h6009);
    chk("t6_a4", {16'd0, 16'(mem_arr[8'hA4])}, 32'h6006);
    chk("t6_a6", {16'd0, 16'(mem_arr[8'hA6])}, 32'h6007);

    // Overlap across the address wrap, and a store/load collision
    cyc(1, 16'hFFFF, 16'h7777, 0, 0, 0);
    drive(0, 0, 0, 1, 16'h0000, 0);
    chk("wrap_conflict", {31'd0, sbif.stall}, 32'd1);
    advance();
    cyc(1, 16'h00B0, 16'h8888, 0, 0, 0);
    drive(1, 16'h00B2, 16'h9999, 1, 16'h00B0, 0);
    chk("collide_ld_data", {16'd0, sbif.ld_data}, 32'h0000);
    chk("collide_mem_read", {31'd0, sbif.mem_read}, 32'd0);
    advance();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
